// File: rtl/max6675_sampler.sv
// Periodic MAX6675 sampler: 4-sample moving average, hysteresis cooling request
// and a 16-byte PicoSoC iomem register window (CTRL/STATUS/TEMP/THRESH).
module max6675_sampler #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned PERIOD_MS   = 250,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0100
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    input  logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_rdata,
    output logic        rd_start,
    input  logic        rd_busy,
    input  logic        rd_ready,
    input  logic [15:0] rd_data,
    output logic        cool_on,
    output logic        fault
);
    localparam int unsigned PCYC = CLK_HZ / 1000 * PERIOD_MS;
    localparam int PW = $clog2(PCYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] PLAST = PW'(PCYC - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_WAIT_PERIOD = 3'd1;
    localparam logic [2:0] S_TRIGGER     = 3'd2;
    localparam logic [2:0] S_WAIT_DONE   = 3'd3;
    localparam logic [2:0] S_UPDATE      = 3'd4;

    logic [2:0]    state;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic [15:0]   word;

    logic          enable;
    logic          en_nxt;
    logic          clr_fault;
    logic          cool_q;
    logic          fault_sticky;
    logic          open_now;
    logic          timeout_seen;
    logic          eval;
    logic [2:0]    fill;
    logic [1:0]    wp;
    logic [11:0]   smp [4];
    logic [11:0]   last_raw;
    logic [11:0]   thr_hi;
    logic [11:0]   thr_lo;
    logic [13:0]   sum;
    logic [11:0]   avg;
    logic          avg_valid;

    logic          sel;
    logic          acc;
    logic          wr;
    logic          wr_ctrl;
    logic          wr_thr;
    logic [31:0]   rd_mux;
    logic          upd;
    logic          timeout;

    // Bus decode: one access per valid phase, ready follows one cycle later.
    assign sel     = iomem_addr[31:4] == BASE_ADDR[31:4];
    assign acc     = iomem_valid && sel && !iomem_ready;
    assign wr      = acc && (iomem_wstrb != 4'h0);
    assign wr_ctrl = wr && (iomem_addr[3:0] == 4'h0);
    assign wr_thr  = wr && (iomem_addr[3:0] == 4'hC);

    always_comb begin
        en_nxt = enable;
        if (wr_ctrl)
            en_nxt = iomem_wdata[0];
    end
    assign clr_fault = wr_ctrl && iomem_wdata[1];

    assign sum       = {2'b00, smp[0]} + {2'b00, smp[1]} + {2'b00, smp[2]} + {2'b00, smp[3]};
    assign avg_valid = (fill == 3'd4);
    assign avg       = avg_valid ? sum[13:2] : 12'h000;

    assign cool_on  = cool_q && avg_valid && enable && !open_now;
    assign fault    = fault_sticky;
    assign rd_start = (state == S_TRIGGER) && !rd_busy;

    assign upd     = (state == S_UPDATE) && en_nxt;
    assign timeout = (state == S_WAIT_DONE) && en_nxt && !rd_ready && (tcnt == TLAST);

    always_comb begin
        rd_mux = 32'h0;
        case (iomem_addr[3:0])
            4'h0:    rd_mux = {31'h0, enable};
            4'h4:    rd_mux = {27'h0, timeout_seen, open_now, avg_valid, fault_sticky, cool_on};
            4'h8:    rd_mux = {4'h0, last_raw, 4'h0, avg};
            4'hC:    rd_mux = {4'h0, thr_lo, 4'h0, thr_hi};
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
        end else begin
            iomem_ready <= acc;
            iomem_rdata <= acc ? rd_mux : 32'h0;
        end
    end

    // Sequencer; enable is looked at through en_nxt so a CTRL write takes
    // effect on the same edge that accepts it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            pcnt  <= '0;
            tcnt  <= '0;
            word  <= 16'h0;
        end else if (!en_nxt) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_WAIT_PERIOD;
                    pcnt  <= '0;
                end
                S_WAIT_PERIOD: begin
                    if (pcnt == PLAST)
                        state <= S_TRIGGER;
                    else
                        pcnt <= pcnt + 1'b1;
                end
                S_TRIGGER: begin
                    pcnt  <= '0;
                    tcnt  <= '0;
                    state <= rd_busy ? S_WAIT_PERIOD : S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (rd_ready) begin
                        word  <= rd_data;
                        state <= S_UPDATE;
                    end else if (tcnt == TLAST) begin
                        pcnt  <= '0;
                        state <= S_WAIT_PERIOD;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_UPDATE: begin
                    pcnt  <= '0;
                    state <= S_WAIT_PERIOD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable   <= 1'b0;
            thr_hi   <= 12'h064;
            thr_lo   <= 12'h058;
            cool_q   <= 1'b0;
            open_now <= 1'b0;
            eval     <= 1'b0;
            fill     <= 3'd0;
            wp       <= 2'd0;
            last_raw <= 12'h000;
            for (int i = 0; i < 4; i++)
                smp[i] <= 12'h000;
        end else begin
            enable <= en_nxt;
            eval   <= 1'b0;
            if (wr_thr) begin
                thr_hi <= iomem_wdata[11:0];
                thr_lo <= iomem_wdata[27:16];
            end
            if (!en_nxt) begin
                fill   <= 3'd0;
                cool_q <= 1'b0;
            end else if (upd && word[2]) begin
                open_now <= 1'b1;
                fill     <= 3'd0;
                cool_q   <= 1'b0;
            end else if (upd) begin
                open_now <= 1'b0;
                last_raw <= word[14:3];
                smp[wp]  <= word[14:3];
                wp       <= wp + 1'b1;
                if (fill != 3'd4)
                    fill <= fill + 1'b1;
                eval <= 1'b1;
            end else if (timeout) begin
                cool_q <= 1'b0;
            end else if (eval && avg_valid) begin
                // hi wins, so a degenerate hi <= lo still behaves as avg >= hi
                if (avg >= thr_hi)
                    cool_q <= 1'b1;
                else if (avg <= thr_lo)
                    cool_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fault_sticky <= 1'b0;
            timeout_seen <= 1'b0;
        end else begin
            if ((upd && word[2]) || timeout)
                fault_sticky <= 1'b1;
            else if (clr_fault)
                fault_sticky <= 1'b0;
            if (timeout)
                timeout_seen <= 1'b1;
            else if (clr_fault)
                timeout_seen <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{iomem_wdata[31:28], iomem_wdata[15:12], word[15], word[1:0], sum[1:0]};

endmodule

// File: tb/tb_max6675_sampler.sv
// Directed bench for max6675_sampler: register reads are scoreboarded and
// checked by a monitor on iomem_ready; a reader model answers rd_start.
module tb_max6675_sampler;
    localparam logic [31:0] BASE = 32'h0300_0100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_rdata;
    logic        rd_start;
    logic        rd_busy;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        cool_on;
    logic        fault;

    max6675_sampler #(
        .CLK_HZ(1000), .PERIOD_MS(10), .TIMEOUT_CYC(50), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb), .iomem_rdata(iomem_rdata),
        .rd_start(rd_start), .rd_busy(rd_busy), .rd_ready(rd_ready), .rd_data(rd_data),
        .cool_on(cool_on), .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // scoreboard
    logic        rdq  [$];
    logic [31:0] expq [$];
    string       nmq  [$];

    always @(negedge clk) begin
        if (iomem_ready) begin
            if (rdq.size() == 0) begin
                chk("spurious_ready", {31'h0, iomem_ready}, 32'h0);
            end else begin
                logic        r;
                logic [31:0] e;
                string       n;
                r = rdq.pop_front();
                e = expq.pop_front();
                n = nmq.pop_front();
                if (r)
                    chk(n, iomem_rdata, e);
            end
        end
    end

    // reader model
    logic [15:0] next_word = 16'h0;
    logic        reader_on = 1'b1;
    int          rd_lat    = 2;
    int          start_cnt = 0;
    int          resp_cnt  = 0;
    int          st_q [$];

    initial begin
        rd_ready = 1'b0;
        rd_data  = 16'h0;
        forever begin
            @(negedge clk);
            if (rd_start) begin
                start_cnt++;
                st_q.push_back(cyc);
                if (reader_on) begin
                    repeat (rd_lat) @(negedge clk);
                    rd_data  = next_word;
                    rd_ready = 1'b1;
                    resp_cnt++;
                    @(negedge clk);
                    rd_ready = 1'b0;
                end
            end
        end
    end

    task automatic bus(input logic [3:0] off, input logic [31:0] d, input logic we,
                       input logic [31:0] exp, input string nm, output int ack);
        int n;
        rdq.push_back(!we);
        expq.push_back(exp);
        nmq.push_back(nm);
        @(posedge clk); #1;
        iomem_valid = 1'b1;
        iomem_addr  = BASE | {28'h0, off};
        iomem_wdata = d;
        iomem_wstrb = we ? 4'hF : 4'h0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!iomem_ready && n < 10);
        chk({"ack_", nm}, {31'h0, iomem_ready}, 32'h1);
        ack = cyc;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string nm);
        int a;
        bus(off, 32'h0, 1'b0, exp, nm, a);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, output int ack);
        bus(off, d, 1'b1, 32'h0, "wr", ack);
    endtask

    task automatic wait_resp(input int n);
        int k = 0;
        while (resp_cnt < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("resp_arrived", resp_cnt >= n, 32'h1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_start(input int n, output int t);
        int k = 0;
        while (start_cnt < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("start_arrived", start_cnt >= n, 32'h1);
        t = (st_q.size() >= n) ? st_q[n-1] : 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d, required end)", cyc);
        $fatal(1);
    end

    initial begin
        int t_en, t1, ts, tf, t2, t3, a, k;
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        iomem_wstrb = 4'h0;
        rd_busy     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_start", {31'h0, rd_start}, 32'h0);
        chk("rst_cool", {31'h0, cool_on}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
        chk("rst_rdata", iomem_rdata, 32'h0);
        resetn = 1'b1;
        rd(4'h0, 32'h0000_0000, "rst_ctrl");
        rd(4'h4, 32'h0000_0000, "rst_status");
        rd(4'h8, 32'h0000_0000, "rst_temp");
        rd(4'hC, 32'h0058_0064, "rst_thresh");
        rd(4'h2, 32'h0000_0000, "unmapped");

        // 25.00 C four times: first trigger one period after enable
        next_word = 16'h0320;
        wr(4'h0, 32'h1, t_en);
        wait_resp(3);
        rd(4'h4, 32'h0000_0000, "status_fill3");
        rd(4'h8, 32'h0064_0000, "temp_fill3");
        wait_resp(4);
        next_word = 16'h02D0;
        chk("first_start_lat", st_q[0] - t_en, 32'd10);
        // 1 trigger + 2 reader latency + 1 update + 10 period cycles
        chk("start_interval", st_q[1] - st_q[0], 32'd14);
        rd(4'h4, 32'h0000_0005, "status_avg100");
        rd(4'h8, 32'h0064_0064, "temp_avg100");
        chk("cool_pin_on", {31'h0, cool_on}, 32'h1);

        // 90 x4: avg 97/95/92/90 all above lo=88, cooling holds
        wait_resp(5);
        rd(4'h8, 32'h005A_0061, "temp_avg97");
        rd(4'h4, 32'h0000_0005, "status_avg97");
        wait_resp(8);
        next_word = 16'h02B0;
        rd(4'h8, 32'h005A_005A, "temp_avg90");
        rd(4'h4, 32'h0000_0005, "status_avg90");

        // 86: avg 89 holds, avg 88 reaches lo and clears
        wait_resp(9);
        rd(4'h8, 32'h0056_0059, "temp_avg89");
        rd(4'h4, 32'h0000_0005, "status_avg89");
        wait_resp(10);
        next_word = 16'h0004;
        rd(4'h4, 32'h0000_0004, "status_avg88");
        wr(4'hC, 32'h0040_0058, a);
        rd(4'h4, 32'h0000_0004, "thresh_no_reeval");
        rd(4'hC, 32'h0040_0058, "thresh_rb");
        chk("cool_pin_off", {31'h0, cool_on}, 32'h0);

        // open thermocouple, then clear fault while staying enabled
        wait_resp(11);
        next_word = 16'h0320;
        rd(4'h4, 32'h0000_000A, "status_open");
        rd(4'h8, 32'h0056_0000, "temp_open");
        wr(4'h0, 32'h3, a);
        rd(4'h4, 32'h0000_0008, "status_clr");
        chk("fault_pin_clr", {31'h0, fault}, 32'h0);
        wait_resp(12);
        reader_on = 1'b0;
        rd(4'h4, 32'h0000_0000, "status_restart");
        rd(4'h8, 32'h0064_0000, "temp_restart");
        rd(4'h0, 32'h0000_0001, "ctrl_enabled");

        // silent reader: rd_ready allowed through cycle start+50, fault the cycle after
        wait_start(13, ts);
        k = 0;
        while (!fault && k < 100) begin
            @(negedge clk);
            k++;
        end
        tf = cyc;
        chk("timeout_lat", tf - ts, 32'd51);
        rd(4'h4, 32'h0000_0012, "status_timeout");
        wait_start(14, t2);
        chk("restart_after_to", t2 - tf, 32'd10);

        // busy reader: triggers skipped
        rd_busy = 1'b1;
        repeat (120) @(negedge clk);
        chk("busy_no_start", start_cnt, 32'd14);

        // disable while waiting for a slow reader
        rd_lat    = 20;
        reader_on = 1'b1;
        rd_busy   = 1'b0;
        wait_start(15, t3);
        wr(4'h0, 32'h0, a);
        wait_resp(13);
        rd(4'h4, 32'h0000_0012, "status_disabled");
        rd(4'h8, 32'h0064_0000, "temp_disabled");
        rd(4'h0, 32'h0000_0000, "ctrl_disabled");
        repeat (30) @(negedge clk);
        chk("idle_no_start", start_cnt, 32'd15);

        // reset in the middle of a read
        wr(4'hC, 32'h0020_0030, a);
        wr(4'h0, 32'h1, t1);
        wait_start(16, t2);
        chk("reen_start_lat", t2 - t1, 32'd10);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        wait_resp(14);
        repeat (5) @(negedge clk);
        rd(4'h4, 32'h0000_0000, "status_midrst");
        rd(4'hC, 32'h0058_0064, "thresh_midrst");
        rd(4'h8, 32'h0000_0000, "temp_midrst");
        rd(4'h0, 32'h0000_0000, "ctrl_midrst");
        repeat (30) @(negedge clk);
        chk("midrst_no_start", start_cnt, 32'd16);
        chk("midrst_fault", {31'h0, fault}, 32'h0);

        k = 0;
        while (rdq.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("sb_drained", rdq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
